id_stage_scb: RTL
=================

// Module: id_stage_scb
// PURPOSE
//  Registered, parametrised decode stage of the RV32IM core, between if_id and id_ex.
//  Decodes the I/R/M/B/S/L/JAL/JALR/AUIPC/LUI/CSR groups into operands and writeback control.
//  Adds a valid/ready handshake, EX-to-ID forwarding and a busy-register scoreboard, so
//  long-latency results (DIV family, loads) stall dependent instructions instead of being lost.
// PARAMETERS
//  XLEN       32  datapath width; operands, immediates and addresses are XLEN bits
//  NREG       32  architectural registers; x0 is hard-wired zero
//  M_EXT      1   1: decode M group; 0: funct7=0000001 is illegal
//  PEND_DEPTH 4   max outstanding long-latency writebacks (1..NREG-1)
//  FWD_EN     1   1: forward EX result into operands; 0: register-file data only
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     reset, asynchronous, active-low
//  inst_valid_i   in   1     if_id holds a valid instruction
//  inst_i         in   32    instruction word
//  inst_addr_i    in   XLEN  instruction address
//  id_ready_o     out  1     stage accepts inst_i this cycle
//  reg1/2_raddr_o out  5     register-file read addresses (combinational from inst_i)
//  reg1/2_rdata_i in   XLEN  register-file read data
//  csr_rdata_i    in   XLEN  CSR read data
//  ex_wen_i       in   1     EX writes a result this cycle
//  ex_waddr_i     in   5     EX destination register
//  ex_wdata_i     in   XLEN  EX result
//  long_done_i    in   1     a long-latency writeback retires this cycle
//  long_done_addr_i in 5     register it retires to
//  flush_i        in   1     branch/jump redirect: kill output and input
//  valid_o        out  1     registered outputs below hold a valid decode
//  ready_i        in   1     id_ex accepts the output
//  inst_o, inst_addr_o, op1_o, op2_o, reg1/2_rdata_o, reg_wen_o, reg_w_addr_o,
//  csr_raddr_o, csr_wen_o, csr_waddr_o, csr_rdata_o, mem_ren_o, mem_raddr_o
//                 out  -     registered decode results, same meaning as in id_ex
//  long_o         out  1     instruction is long-latency (reg_wen_o=0, writes later)
//  illegal_o      out  1     opcode/funct3/funct7 not decodable
// BEHAVIOUR
//  Reset: valid_o, reg_wen_o, csr_wen_o, mem_ren_o, long_o, illegal_o = 0; all data 0;
//   busy vector and pending count = 0.
//  Latency: accepted instruction appears on outputs at the next rising edge (1 cycle).
//  Output register loads when (!valid_o || ready_i); it holds stable while valid_o && !ready_i.
//  Accept: id_ready_o = (!valid_o || ready_i) && !hazard && !flush_i; accept = inst_valid_i && id_ready_o.
//  No accept but output consumed: valid_o -> 0 (bubble).
//  Operand select per source rs (rs!=0): FWD_EN && ex_wen_i && ex_waddr_i==rs -> ex_wdata_i,
//   else regs data. rs==0 -> 0. Forwarded value feeds op1/op2, reg*_rdata_o and mem_raddr_o.
//  mem_raddr_o = rs1 operand + sign-extended imm[11:0], modulo 2^XLEN.
//  Immediates sign-extended to XLEN; shift amount = inst[24:20] zero-extended.
//  Hazard: any used rs with busy[rs]=1 and not (long_done_i && long_done_addr_i==rs);
//   or long op with busy[rd]=1 (WAW); or long op with count==PEND_DEPTH and no long_done_i.
//  Scoreboard: on accept of long op with rd!=0 set busy[rd], count+1; on long_done_i clear
//   busy[addr], count-1; both same cycle: net count unchanged, set wins if same register.
//   x0 never busy; long op with rd=0 does not occupy a slot.
//  Long ops: DIV/DIVU/REM/REMU (M_EXT=1) and LB/LH/LW/LBU/LHU; long_o=1, reg_wen_o=0.
//  Illegal: illegal_o=1, all write/read enables 0; still passes through the handshake.
//  flush_i: valid_o -> 0 next edge; no accept; scoreboard NOT cleared.
//  long_done_i for a register not busy: ignored, count unchanged.
//  Reset mid-stall: all state cleared asynchronously; first post-reset instruction sees no hazards.
// TESTING
//  ADDI x1,x0,5 with ready_i=1 -> next cycle valid_o=1, op1_o=0, op2_o=5, reg_w_addr_o=1, reg_wen_o=1.
//  Fill: LW x5; ADD x6,x5,x1 -> ADD stalls (id_ready_o=0) until long_done_addr_i=5; accepted that same cycle.
//  ex_wen_i=1, ex_waddr_i=3, ex_wdata_i=0xDEAD, regs give 0 for SUB x4,x3,x3 -> op1_o=op2_o=0xDEAD.
//  Issue 4 DIVs to x7..x10 (PEND_DEPTH=4) -> 5th long op stalls; one long_done_i frees it same cycle.
//  ready_i=0 for 3 cycles with valid_o=1 -> all outputs unchanged; flush_i then -> valid_o=0, busy kept.
//  M_EXT=0, MUL x1,x2,x3 -> illegal_o=1, reg_wen_o=0; rst low mid-stall -> busy=0, valid_o=0.

Source files
------------

// File: rtl/id_stage_scb.sv
// id_stage_scb: registered RV32IM decode stage with valid/ready handshake, EX-to-ID forwarding
// and a busy-register scoreboard that stalls consumers of outstanding long-latency results.
module id_stage_scb #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int M_EXT      = 1,
  parameter int PEND_DEPTH = 4,
  parameter int FWD_EN     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic            id_ready_o,
  output logic [4:0]      reg1_raddr_o,
  output logic [4:0]      reg2_raddr_o,
  input  logic [XLEN-1:0] reg1_rdata_i,
  input  logic [XLEN-1:0] reg2_rdata_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  input  logic            ex_wen_i,
  input  logic [4:0]      ex_waddr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            long_done_i,
  input  logic [4:0]      long_done_addr_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] reg1_rdata_o,
  output logic [XLEN-1:0] reg2_rdata_o,
  output logic            reg_wen_o,
  output logic [4:0]      reg_w_addr_o,
  output logic [XLEN-1:0] csr_raddr_o,
  output logic            csr_wen_o,
  output logic [XLEN-1:0] csr_waddr_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            mem_ren_o,
  output logic [XLEN-1:0] mem_raddr_o,
  output logic            long_o,
  output logic            illegal_o
);
  localparam int CW = $clog2(PEND_DEPTH + 1);

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_a, w_b, w_imm_i, w_imm_s, w_imm_u, w_op1, w_op2;
  logic            w_legal, w_use1, w_use2, w_wen, w_csr, w_load, w_long;
  logic            w_lk, w_done, w_hazard, w_accept, w_set;
  logic [NREG-1:0] w_clr, w_setv;

  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_cnt;
  logic            r_valid, r_wen, r_csr_wen, r_mren, r_long, r_ill;
  logic [31:0]     r_inst;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_pc, r_op1, r_op2, r_rd1, r_rd2, r_csr_addr, r_csr_rdata, r_maddr;

  assign w_opc   = inst_i[6:0];
  assign w_rd    = inst_i[11:7];
  assign w_f3    = inst_i[14:12];
  assign w_rs1   = inst_i[19:15];
  assign w_rs2   = inst_i[24:20];
  assign w_f7    = inst_i[31:25];
  assign w_imm_i = XLEN'($signed(inst_i[31:20]));
  assign w_imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign w_imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));

  assign reg1_raddr_o = w_rs1;
  assign reg2_raddr_o = w_rs2;

  assign w_a = (w_rs1 == 5'd0) ? '0 :
               (FWD_EN != 0 && ex_wen_i && ex_waddr_i == w_rs1) ? ex_wdata_i : reg1_rdata_i;
  assign w_b = (w_rs2 == 5'd0) ? '0 :
               (FWD_EN != 0 && ex_wen_i && ex_waddr_i == w_rs2) ? ex_wdata_i : reg2_rdata_i;

  always_comb begin
    w_legal = 1'b0;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_wen   = 1'b0;
    w_csr   = 1'b0;
    w_load  = 1'b0;
    w_long  = 1'b0;
    w_op1   = '0;
    w_op2   = '0;
    case (w_opc)
      7'b0010011: begin
        w_legal = (w_f3 == 3'b001) ? (w_f7 == 7'd0) :
                  (w_f3 == 3'b101) ? (w_f7 == 7'd0 || w_f7 == 7'b0100000) : 1'b1;
        w_use1  = 1'b1;
        w_wen   = 1'b1;
        w_op1   = w_a;
        w_op2   = (w_f3[1:0] == 2'b01) ? XLEN'(w_rs2) : w_imm_i;
      end
      7'b0110011: begin
        w_legal = w_f7 == 7'd0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                  (M_EXT != 0 && w_f7 == 7'b0000001);
        w_long  = M_EXT != 0 && w_f7 == 7'b0000001 && w_f3[2];
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_wen   = !w_long;
        w_op1   = w_a;
        w_op2   = w_b;
      end
      7'b0000011: begin
        w_legal = w_f3 != 3'b011 && w_f3[2:1] != 2'b11;
        w_use1  = 1'b1;
        w_load  = 1'b1;
        w_long  = 1'b1;
        w_op1   = w_a;
        w_op2   = w_imm_i;
      end
      7'b0100011: begin
        w_legal = !w_f3[2] && w_f3 != 3'b011;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_op1   = w_a;
        w_op2   = w_imm_s;
      end
      7'b1100011: begin
        w_legal = w_f3[2:1] != 2'b01;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_op1   = w_a;
        w_op2   = w_b;
      end
      7'b1101111: begin
        w_legal = 1'b1;
        w_wen   = 1'b1;
        w_op1   = inst_addr_i;
        w_op2   = XLEN'(4);
      end
      7'b1100111: begin
        w_legal = w_f3 == 3'b000;
        w_use1  = 1'b1;
        w_wen   = 1'b1;
        w_op1   = inst_addr_i;
        w_op2   = XLEN'(4);
      end
      7'b0110111: begin
        w_legal = 1'b1;
        w_wen   = 1'b1;
        w_op1   = w_imm_u;
      end
      7'b0010111: begin
        w_legal = 1'b1;
        w_wen   = 1'b1;
        w_op1   = inst_addr_i;
        w_op2   = w_imm_u;
      end
      7'b1110011: begin
        w_legal = w_f3[1:0] != 2'b00;
        w_use1  = !w_f3[2];
        w_wen   = 1'b1;
        w_csr   = 1'b1;
        w_op1   = w_f3[2] ? XLEN'(w_rs1) : w_a;
        w_op2   = csr_rdata_i;
      end
      default: ;
    endcase
  end

  // A retirement only counts when it targets a register that is actually busy
  assign w_done   = long_done_i && r_busy[long_done_addr_i];
  assign w_lk     = w_legal && w_long;
  assign w_hazard = (w_legal && w_use1 && r_busy[w_rs1] && !(w_done && long_done_addr_i == w_rs1)) ||
                    (w_legal && w_use2 && r_busy[w_rs2] && !(w_done && long_done_addr_i == w_rs2)) ||
                    (w_lk && r_busy[w_rd]) ||
                    (w_lk && r_cnt == CW'(PEND_DEPTH) && !w_done);
  assign id_ready_o = (!r_valid || ready_i) && !w_hazard && !flush_i;
  assign w_accept   = inst_valid_i && id_ready_o;
  assign w_set      = w_accept && w_lk && w_rd != 5'd0;
  assign w_clr      = w_done ? NREG'(1) << long_done_addr_i : '0;
  assign w_setv     = w_set ? NREG'(1) << w_rd : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_setv;
      r_cnt  <= r_cnt + CW'(w_set) - CW'(w_done);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_wen       <= 1'b0;
      r_csr_wen   <= 1'b0;
      r_mren      <= 1'b0;
      r_long      <= 1'b0;
      r_ill       <= 1'b0;
      r_inst      <= '0;
      r_pc        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_waddr     <= '0;
      r_csr_addr  <= '0;
      r_csr_rdata <= '0;
      r_maddr     <= '0;
    end else if (flush_i || ((!r_valid || ready_i) && !w_accept)) begin
      r_valid   <= 1'b0;
      r_wen     <= 1'b0;
      r_csr_wen <= 1'b0;
      r_mren    <= 1'b0;
      r_long    <= 1'b0;
      r_ill     <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_wen       <= w_legal && w_wen;
      r_csr_wen   <= w_legal && w_csr;
      r_mren      <= w_legal && w_load;
      r_long      <= w_lk;
      r_ill       <= !w_legal;
      r_inst      <= inst_i;
      r_pc        <= inst_addr_i;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_rd1       <= w_a;
      r_rd2       <= w_b;
      r_waddr     <= w_rd;
      r_csr_addr  <= XLEN'(inst_i[31:20]);
      r_csr_rdata <= csr_rdata_i;
      r_maddr     <= w_a + w_imm_i;
    end
  end

  assign valid_o      = r_valid;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_pc;
  assign op1_o        = r_op1;
  assign op2_o        = r_op2;
  assign reg1_rdata_o = r_rd1;
  assign reg2_rdata_o = r_rd2;
  assign reg_wen_o    = r_wen;
  assign reg_w_addr_o = r_waddr;
  assign csr_raddr_o  = r_csr_addr;
  assign csr_waddr_o  = r_csr_addr;
  assign csr_wen_o    = r_csr_wen;
  assign csr_rdata_o  = r_csr_rdata;
  assign mem_ren_o    = r_mren;
  assign mem_raddr_o  = r_maddr;
  assign long_o       = r_long;
  assign illegal_o    = r_ill;
endmodule
